dual_rail_token_source: RTL
===========================

# dual_rail_token_source

Clocked token source that drains a FIFO of synchronously written words onto a dual-rail output link, one token per handshake. It supports two-phase (transition) and four-phase (return-to-zero) encodings. It is the sequential successor of the combinational single-shot value injector. It sits at the boundary between the synchronous test/control domain and the asynchronous pipeline, and drives stimulus tokens and initial tokens into rings.

## Interface
- ENC, "TP", link encoding: "TP" two-phase transition signalling, any other value four-phase RZ
- WIDTH, 1, data bits per token
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  permits launching new tokens; a token in flight always completes
- wr_valid  in  1  write request
- wr_data  in  WIDTH  word to enqueue
- wr_ready  out  1  FIFO not full
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  a token is in flight (state ≠ IDLE)
- out  out  [WIDTH-1:0][1:0]  dual-rail link; [b][1] true rail, [b][0] false rail; driven directly from flops
- ack  in  1  completion acknowledge from the downstream side; asynchronous to clk

## Operation
- Reset (rst=0, immediate): out=0, FIFO empty (level=0, wr_ready=1), busy=0, phase=0, state=IDLE, both ack synchroniser flops=0.
- Write: wr_valid && wr_ready at a clk edge enqueues wr_data. A write when full is ignored, with no state change. wr_ready = (level != DEPTH), depends only on occupancy.
- ack passes through a 2-flop synchroniser; FSM uses ack_s only.
- FSM states: IDLE, WAIT_ACK, WAIT_NACK (WAIT_NACK used for four-phase only).
- IDLE → WAIT_ACK when en && level>0:
  - TP: out[b][1] toggles if head[b]=1, else out[b][0] toggles; phase flips.
  - Four-phase: out[b] = {head[b], !head[b]}.
- WAIT_ACK:
  - TP: when ack_s == phase, pop head, go to IDLE.
  - Four-phase: when ack_s=1, pop head, drive out=0 (spacer), go to WAIT_NACK.
- WAIT_NACK: when ack_s=0, go to IDLE.
- Simultaneous push and pop on one edge: level unchanged, both take effect. Pointers wrap modulo DEPTH.
- en deasserted mid-token: the current handshake completes normally, and no new token launches until en=1.
- Reset mid-token: link returns to all-zero immediately. TP phase restarts at 0, so the downstream must be reset together with this block.

## Timing
- Write at edge k into an empty FIFO with en=1: level=1 after edge k, out changes at edge k+1, busy=1 after edge k+1.
- ack change sampled at edge m: ack_s valid after edge m+1; the FSM acts (pop/spacer/IDLE) at edge m+2.
- Back-to-back tokens: the next launch is on the edge after returning to IDLE. The minimum token period in clk cycles is 2 + ack round-trip + 3 for TP, and twice that for four-phase.
- out is glitch-free. In TP exactly one rail per bit toggles per token. In four-phase the link passes through all-zero between codewords.
- level updates on the same edge as the push/pop that changes it.

## Test plan
- TP, WIDTH=4: write 4'b1010 then 4'b0110, responder echoes ack = XOR-parity of transitions. Required: first token toggles rails [3][1],[2][0],[1][1],[0][0]; second token toggles only after ack toggles; level 2→1→0.
- Four-phase, WIDTH=2: write 2'b01. Required: out=={{0,1},{1,0}} until ack=1 is seen plus 2 cycles, then out=0; busy=0 two cycles after ack falls.
- Fill with DEPTH=4 writes while ack is held. Required: wr_ready=0 and level=4; a 5th write is ignored; after one completion wr_ready=1, and a push plus pop on the same edge keeps level=3.
- en=0 with 2 words queued. Required: out stays constant and busy=0. Then en=1 for one cycle: exactly one token launches and completes even if en drops.
- Assert rst low during WAIT_ACK with 3 words queued. Required: immediately out=0, level=0, busy=0; after release, a new write launches a TP token with phase starting at 0.
- Pointer wrap: stream 3×DEPTH distinct words. Required: tokens decode in write order with no loss or duplication.

Source files
------------

// File: rtl/dual_rail_token_source.sv
// Clocked dual-rail token source: drains a small FIFO onto a two-phase or four-phase link,
// one token per handshake with a synchronised asynchronous acknowledge.
module dual_rail_token_source #(
   parameter string       ENC   = "TP",
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic [WIDTH-1:0][1:0]    out,
   input  logic                     ack
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam bit          TP   = (ENC == "TP");
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_NACK} state_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             ack_m;
   logic             ack_s;
   logic             phase;
   state_t           state;
   logic             push;
   logic             pop;
   logic             launch;
   logic [WIDTH-1:0] head;

   assign wr_ready = (level != FULL);

   always_comb begin
      head   = mem[rd_ptr];
      push   = wr_valid && wr_ready;
      launch = (state == IDLE) && en && (level != '0);
      // Two-phase completes when the echoed level matches the phase just sent.
      pop    = (state == WAIT_ACK) && (TP ? (ack_s == phase) : ack_s);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_m  <= 1'b0;
         ack_s  <= 1'b0;
         state  <= IDLE;
         phase  <= 1'b0;
         busy   <= 1'b0;
         out    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         ack_m <= ack;
         ack_s <= ack_m;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
         case (state)
            IDLE: begin
               if (launch) begin
                  state <= WAIT_ACK;
                  busy  <= 1'b1;
                  if (TP) begin
                     phase <= ~phase;
                     for (int unsigned b = 0; b < WIDTH; b++) begin
                        if (head[b]) out[b][1] <= ~out[b][1];
                        else         out[b][0] <= ~out[b][0];
                     end
                  end else begin
                     for (int unsigned b = 0; b < WIDTH; b++)
                        out[b] <= {head[b], ~head[b]};
                  end
               end
            end
            WAIT_ACK: begin
               if (pop) begin
                  if (TP) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     out   <= '0;
                     state <= WAIT_NACK;
                  end
               end
            end
            WAIT_NACK: begin
               if (!ack_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
